nmr_scan_sched: RTL and testbench

Scan-level scheduler that sequences the NMR bitstream pulse sequencer (NMR_bstrm_pls_cnt) across repeated acquisitions. On a host RUN request it issues NUM_SCANS sequencer START pulses. Each scan waits for the sequencer DONE, then inserts a repetition delay (TR) before the next scan. It also handles abort and watchdog timeout without ever overlapping two sequencer runs.

---
 rtl/nmr_sched_pkg.sv | 7 +
 rtl/nmr_dly_cnt.sv | 18 +
 rtl/nmr_scan_sched.sv | 127 ++++++++++++
 tb/tb_nmr_scan_sched.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nmr_sched_pkg.sv
// nmr_sched_pkg: shared state type and default widths for the NMR scan scheduler
package nmr_sched_pkg;
  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, TR_WAIT, DRAIN} sched_state_t;
  localparam int SCAN_WIDTH_DEF = 16;
  localparam int TR_WIDTH_DEF = 32;
  localparam int TO_WIDTH_DEF = 32;
endpackage

// File: rtl/nmr_dly_cnt.sv
// nmr_dly_cnt: loadable down-counter that saturates at zero and flags it
module nmr_dly_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  assign zero_o = cnt_q == '0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (!zero_o) cnt_q <= cnt_q - 1'b1;
  end
endmodule

// File: rtl/nmr_scan_sched.sv
// nmr_scan_sched: sequences repeated pulse-sequencer scans with TR delay, abort and watchdog
module nmr_scan_sched
  import nmr_sched_pkg::*;
#(
  parameter int SCAN_WIDTH = SCAN_WIDTH_DEF,
  parameter int TR_WIDTH = TR_WIDTH_DEF,
  parameter int TO_WIDTH = TO_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  run_i,
  input  logic                  abort_i,
  input  logic [SCAN_WIDTH-1:0] num_scans_i,
  input  logic [TR_WIDTH-1:0]   tr_dly_i,
  input  logic [TO_WIDTH-1:0]   timeout_i,
  output logic                  seq_start_o,
  input  logic                  seq_done_i,
  output logic [SCAN_WIDTH-1:0] scan_idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_timeout_o,
  output logic                  aborted_o
);
  sched_state_t state_q, state_d;
  logic [SCAN_WIDTH-1:0] num_q, idx_q, idx_d, idx_inc;
  logic [TR_WIDTH-1:0] tr_q, tr_val;
  logic [TO_WIDTH-1:0] to_q, wd_val;
  logic err_q, err_d, abt_q, abt_d, done_q, done_d, sd_prev_q;
  logic tr_load, wd_load, tr_zero, wd_zero, sd_rise, wd_exp;
  assign idx_inc = idx_q + 1'b1;
  assign tr_val = tr_q - 1'b1;
  assign wd_val = to_q - 1'b1;
  // a DONE level held across cycles is counted only on its rising edge
  assign sd_rise = seq_done_i && !sd_prev_q;
  assign wd_exp = (to_q != '0) && wd_zero;
  assign seq_start_o = state_q == START;
  assign busy_o = state_q != IDLE;
  assign scan_idx_o = idx_q;
  assign done_o = done_q;
  assign err_timeout_o = err_q;
  assign aborted_o = abt_q;
  nmr_dly_cnt #(.W(TR_WIDTH)) u_tr_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (tr_load),
    .val_i  (tr_val),
    .zero_o (tr_zero)
  );
  nmr_dly_cnt #(.W(TO_WIDTH)) u_wd_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (wd_load),
    .val_i  (wd_val),
    .zero_o (wd_zero)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    err_d = err_q;
    abt_d = abt_q;
    done_d = 1'b0;
    tr_load = 1'b0;
    wd_load = 1'b0;
    unique case (state_q)
      IDLE: if (run_i) begin
        idx_d = '0;
        err_d = 1'b0;
        abt_d = 1'b0;
        done_d = num_scans_i == '0;
        state_d = num_scans_i == '0 ? IDLE : START;
      end
      START: begin
        wd_load = 1'b1;
        state_d = abort_i ? DRAIN : WAIT_DONE;
      end
      WAIT_DONE: if (sd_rise) begin
        idx_d = idx_inc;
        abt_d = abort_i;
        done_d = (idx_inc == num_q) || abort_i;
        tr_load = !done_d && tr_q != '0;
        state_d = done_d ? IDLE : (tr_q == '0 ? START : TR_WAIT);
      end else if (wd_exp) begin
        err_d = 1'b1;
        abt_d = abort_i;
        done_d = 1'b1;
        state_d = IDLE;
      end else if (abort_i) state_d = DRAIN;
      TR_WAIT: if (abort_i) begin
        abt_d = 1'b1;
        done_d = 1'b1;
        state_d = IDLE;
      end else if (tr_zero) state_d = START;
      DRAIN: if (sd_rise || wd_exp) begin
        abt_d = 1'b1;
        err_d = !sd_rise;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      num_q <= '0;
      tr_q <= '0;
      to_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      abt_q <= 1'b0;
      done_q <= 1'b0;
      sd_prev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      err_q <= err_d;
      abt_q <= abt_d;
      done_q <= done_d;
      sd_prev_q <= seq_done_i;
      if (state_q == IDLE && run_i) begin
        num_q <= num_scans_i;
        tr_q <= tr_dly_i;
        to_q <= timeout_i;
      end
    end
  end
endmodule

// File: tb/tb_nmr_scan_sched.sv
// tb_nmr_scan_sched: scoreboard bench with a timeline model of scan starts and run termination
module tb_nmr_scan_sched;
  typedef struct {
    bit is_done;
    int c;
    int idx;
    bit err;
    bit abt;
  } ev_t;
  logic clk = 1'b0, rst_i = 1'b1, run_i = 1'b0, abort_i = 1'b0, seq_done_i = 1'b0;
  logic [15:0] num_scans_i = '0, scan_idx_o;
  logic [31:0] tr_dly_i = '0, timeout_i = '0;
  logic seq_start_o, busy_o, done_o, err_timeout_o, aborted_o;
  int cyc = 0, n_chk = 0, n_fail = 0, b_lo = 1, b_hi = 0, endc = 0;
  int lat[16], hold[16];
  int run_id = 0, bfm_run = -1, bfm_k = 0, done_at = 0, done_until = 0;
  ev_t expq[$];
  ev_t mon_e;

  nmr_scan_sched dut (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .abort_i(abort_i),
    .num_scans_i(num_scans_i), .tr_dly_i(tr_dly_i), .timeout_i(timeout_i),
    .seq_start_o(seq_start_o), .seq_done_i(seq_done_i), .scan_idx_o(scan_idx_o),
    .busy_o(busy_o), .done_o(done_o), .err_timeout_o(err_timeout_o), .aborted_o(aborted_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // sequencer model: DONE rises lat cycles after START and stays high for hold cycles
  always @(negedge clk) begin
    if (seq_start_o) begin
      if (bfm_run != run_id) begin
        bfm_run = run_id;
        bfm_k = 0;
      end
      done_at = cyc + lat[bfm_k];
      done_until = done_at + hold[bfm_k];
      if (bfm_k < 15) bfm_k++;
    end
  end
  always @(posedge clk) begin
    #1 seq_done_i = (cyc >= done_at) && (cyc < done_until);
  end

  always @(negedge clk) begin
    if (!rst_i) begin
      chk("busy", busy_o, (cyc >= b_lo) && (cyc <= b_hi));
      if (seq_start_o || done_o) begin
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: start=%0d done=%0d with empty scoreboard (cycle %0d)", seq_start_o, done_o, cyc);
        end else begin
          mon_e = expq.pop_front();
          chk("event_kind", done_o, mon_e.is_done);
          chk("event_cycle", cyc, mon_e.c);
          chk("scan_idx", scan_idx_o, mon_e.idx);
          chk("err_timeout", err_timeout_o, mon_e.err);
          chk("aborted", aborted_o, mon_e.abt);
        end
      end
    end
  end

  function automatic void push_ev(bit d, int c, int idx, bit err, bit abt);
    ev_t e;
    e.is_done = d;
    e.c = c;
    e.idx = idx;
    e.err = err;
    e.abt = abt;
    expq.push_back(e);
    if (d) begin
      b_hi = c - 1;
      endc = c;
    end
  endfunction

  // expected timeline: scan k starts at s, its DONE is sampled at s+lat, next start TR cycles later
  task automatic do_run(int n, int tr, int to, int ab_off, int rst_off);
    int t, s, dec, ab, rc;
    bit fin, tmo;
    run_id++;
    @(posedge clk);
    #1;
    t = cyc;
    ab = ab_off < 0 ? -1 : t + ab_off;
    rc = rst_off < 0 ? -1 : t + rst_off;
    b_lo = t + 1;
    s = t + 1;
    fin = 0;
    if (n == 0) push_ev(1, t + 1, 0, 0, 0);
    for (int k = 0; k < n && !fin; k++) begin
      push_ev(0, s, k, 0, 0);
      tmo = to != 0 && lat[k] > to;
      dec = tmo ? s + to : s + lat[k];
      fin = 1;
      if (tmo) push_ev(1, dec + 1, k, 1, ab >= s && ab <= dec);
      else if (ab >= s && ab < dec) push_ev(1, dec + 1, k, 0, 1);
      else if (ab == dec || k == n - 1) push_ev(1, dec + 1, k + 1, 0, ab == dec);
      else if (ab > dec && ab <= dec + tr) push_ev(1, ab + 1, k + 1, 0, 1);
      else begin
        fin = 0;
        s = dec + 1 + tr;
      end
    end
    num_scans_i = 16'(n);
    tr_dly_i = 32'(tr);
    timeout_i = 32'(to);
    run_i = 1'b1;
    abort_i = ab == t;
    @(posedge clk);
    #1;
    run_i = 1'b0;
    while (cyc < endc + 2) begin
      abort_i = cyc == ab;
      if (cyc == rc) begin
        b_hi = cyc - 1;
        #2 rst_i = 1'b1;
        #1;
        chk("rst_seq_start", seq_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_scan_idx", scan_idx_o, 0);
        chk("rst_err", err_timeout_o, 0);
        chk("rst_aborted", aborted_o, 0);
        expq.delete();
        @(posedge clk);
        #1 rst_i = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    abort_i = 1'b0;
  endtask

  task automatic set_lat(int l, int h);
    for (int i = 0; i < 16; i++) begin
      lat[i] = l;
      hold[i] = h;
    end
  endtask

  initial begin
    set_lat(10, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_seq_start", seq_start_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_scan_idx", scan_idx_o, 0);
    chk("reset_err", err_timeout_o, 0);
    chk("reset_aborted", aborted_o, 0);
    rst_i = 1'b0;
    set_lat(20, 1);
    do_run(1, 5, 0, -1, -1);
    set_lat(10, 2);
    do_run(3, 4, 0, -1, -1);
    set_lat(6, 3);
    do_run(3, 0, 0, -1, -1);
    do_run(0, 3, 0, -1, -1);
    set_lat(1000, 1);
    do_run(1, 2, 8, -1, -1);
    set_lat(5, 1);
    do_run(1, 2, 0, -1, -1);
    set_lat(10, 1);
    do_run(4, 3, 0, 17, -1);
    do_run(4, 3, 0, 25, -1);
    do_run(3, 2, 0, 0, -1);
    set_lat(5, 1);
    do_run(3, 50, 0, -1, 20);
    do_run(2, 3, 0, -1, -1);
    repeat (60) begin
      for (int i = 0; i < 16; i++) begin
        lat[i] = int'($urandom_range(4, 12));
        hold[i] = int'($urandom_range(1, 3));
      end
      do_run(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
             $urandom_range(0, 2) == 0 ? 0 : int'($urandom_range(1, 14)),
             $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 60)) : -1, -1);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drain", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
